// File: rtl/seg_scan_ctrl.sv
// Scan controller for multiplexed 7-segment digits sharing one BCD decoder.
// Steps BLANK/SHOW per digit, applies new frame data only at frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   din,
    input  logic                      load,
    input  logic                      lamp_test,
    input  logic                      blank,
    input  logic                      lz_en,
    output logic [3:0]                seg_a,
    output logic                      lt_n,
    output logic                      bi_n,
    output logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic                      frame_done
);

    localparam int CMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;
    typedef logic [NUM_DIGITS-1:0][3:0] frame_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    frame_t                pending, active, active_nxt;
    logic                  upd;
    logic                  boundary;
    logic                  zhi;
    logic [NUM_DIGITS-1:0] supp;
    logic [3:0]            seg_nxt;
    logic                  lt_nxt, bi_nxt, fd_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CW'(1);
        boundary  = 1'b0;
        if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nxt = ST_SHOW;
                cnt_nxt   = '0;
            end
        end else begin
            if (cnt == SHOW_LAST) begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
                if (idx == IDX_LAST) begin
                    idx_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
        end
    end

    // Outputs are registered from next-state values so they move with the FSM.
    always_comb begin
        active_nxt = (boundary && upd) ? pending : active;
        zhi  = 1'b1;
        supp = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zhi = zhi & (active_nxt[k] == 4'd0);
            if (k > 0) supp[k] = lz_en & zhi;
        end
        seg_nxt = active_nxt[idx_nxt];
        sel_nxt = '1;
        lt_nxt  = 1'b1;
        bi_nxt  = 1'b0;
        if (state_nxt == ST_SHOW) begin
            sel_nxt[idx_nxt] = 1'b0;
            lt_nxt = ~lamp_test;
            bi_nxt = ~(blank | supp[idx_nxt]);
        end
        fd_nxt = (state_nxt == ST_SHOW) && (idx_nxt == IDX_LAST) && (cnt_nxt == SHOW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            idx        <= '0;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            upd        <= 1'b0;
            seg_a      <= 4'd0;
            lt_n       <= 1'b1;
            bi_n       <= 1'b0;
            dig_sel_n  <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            // A load on the boundary cycle keeps upd set for the next frame.
            if (load) begin
                pending <= din;
                upd     <= 1'b1;
            end else if (boundary) begin
                upd     <= 1'b0;
            end
            seg_a      <= seg_nxt;
            lt_n       <= lt_nxt;
            bi_n       <= bi_nxt;
            dig_sel_n  <= sel_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 8 lit / 2 dead cycles, 40-cycle frame).
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int CD    = 8;
    localparam int BC    = 2;
    localparam int SLOT  = CD + BC;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   din = '0;
    logic          load = 1'b0, lamp_test = 1'b0, blank = 1'b0, lz_en = 1'b0;
    logic [3:0]    seg_a;
    logic          lt_n, bi_n, frame_done;
    logic [N-1:0]  dig_sel_n;

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Per-frame expected display value and control settings.
    logic [15:0] fval [9] = '{16'h0000, 16'h4321, 16'h9999, 16'h5678, 16'h0105,
                              16'h0000, 16'h0000, 16'h0000, 16'h8765};
    bit          flz  [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    bit          fbl  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    bit          flt  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .load(load), .lamp_test(lamp_test),
        .blank(blank), .lz_en(lz_en), .seg_a(seg_a), .lt_n(lt_n), .bi_n(bi_n),
        .dig_sel_n(dig_sel_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_dig"}, 32'(dig_sel_n), 32'hF);
        chk({pfx, "_seg"}, 32'(seg_a), 32'h0);
        chk({pfx, "_bi"},  32'(bi_n), 32'h0);
        chk({pfx, "_lt"},  32'(lt_n), 32'h1);
        chk({pfx, "_fd"},  32'(frame_done), 32'h0);
    endtask

    // Expected outputs from position within the frame.
    task automatic chk_cycle(input logic [15:0] v, input bit lz, input bit bl, input bit lt);
        int p, d, r;
        bit show, sup;
        logic [15:0] vv;
        logic [3:0]  edig, eseg;
        p    = k % FRAME;
        d    = p / SLOT;
        r    = p % SLOT;
        show = (r >= BC);
        vv   = v >> (4 * d);
        eseg = vv[3:0];
        sup  = lz && (d > 0) && (vv == 16'h0);
        edig = 4'hF;
        if (show) edig[d] = 1'b0;
        chk("dig", 32'(dig_sel_n), 32'(edig));
        chk("seg", 32'(seg_a), 32'(eseg));
        chk("bi",  32'(bi_n), show ? 32'(!(bl || sup)) : 32'h0);
        chk("lt",  32'(lt_n), show ? 32'(!lt) : 32'h1);
        chk("fd",  32'(frame_done), 32'(p == FRAME - 1));
    endtask

    initial begin
        int f, run;
        bit prev_blank;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        k = 0;

        while (k < 345) begin
            f = k / FRAME;
            chk_cycle(fval[f], flz[f], fbl[f], flt[f]);
            load = 1'b0;
            case (k)
                0:   begin load = 1'b1; din = 16'h4321; end
                55:  begin load = 1'b1; din = 16'h9999; end  // mid-frame
                79:  begin load = 1'b1; din = 16'h5678; end  // boundary cycle
                130: begin load = 1'b1; din = 16'h0105; end
                170: begin load = 1'b1; din = 16'h0000; end
                290: begin load = 1'b1; din = 16'h8765; end
                325: begin load = 1'b1; din = 16'hABCD; end
                default: ;
            endcase
            if (k % FRAME == FRAME - 1) begin
                lz_en     = flz[f + 1];
                blank     = fbl[f + 1];
                lamp_test = flt[f + 1];
            end
            step();
        end

        // SHOW(2) of frame 8 with 0xABCD pending; reset with no clock edge.
        chk_cycle(fval[8], 1'b0, 1'b0, 1'b0);
        chk("pre_rst_seg", 32'(seg_a), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        while (k < 2 * FRAME) begin
            chk_cycle(16'h0000, 1'b0, 1'b0, 1'b0);
            step();
        end

        run = 0;
        prev_blank = 1'b1;
        repeat (10000) begin
            chk("onehot", 32'($countones(~dig_sel_n) <= 1), 32'h1);
            if (dig_sel_n == 4'hF) begin
                run++;
                prev_blank = 1'b1;
            end else begin
                if (prev_blank) chk("dead", 32'(run), 32'(BC));
                run = 0;
                prev_blank = 1'b0;
            end
            load      = ($urandom_range(0, 15) == 0);
            din       = 16'($urandom);
            lamp_test = ($urandom_range(0, 3) == 0);
            blank     = ($urandom_range(0, 3) == 0);
            lz_en     = $urandom_range(0, 1) == 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
